// File: rtl/dmem_arbiter.sv
// Purpose: round-robin two-port front end sharing one single-port data_mem between CPU LSU (port 0) and DMA/debug (port 1).
// Latency: write ack 2 cycles, read ack 3 cycles after the cycle the requester raises req; one access in flight.
// Backpressure: requester holds req and command stable until its ack pulse; a losing port waits and is granted next.
module dmem_arbiter #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              arb_clk,
    input  logic              arb_rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [AWIDTH-1:0] addr0,
    input  logic [DWIDTH-1:0] wdata0,
    output logic              ack0,
    output logic [DWIDTH-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [DWIDTH-1:0] wdata1,
    output logic              ack1,
    output logic [DWIDTH-1:0] rdata1,
    output logic              mem_we,
    output logic              mem_re,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // prio names the port that wins a tie; gnt_id remembers who owns the access in flight
    logic prio;
    logic prio_nxt;
    logic gnt_id;
    logic gnt_id_nxt;

    // winner of the current IDLE-cycle arbitration and its command fields
    logic              win;
    logic              win_we;
    logic [AWIDTH-1:0] win_addr;
    logic [DWIDTH-1:0] win_wdata;

    // next values for the registered outputs
    logic              ack0_nxt;
    logic              ack1_nxt;
    logic [DWIDTH-1:0] rdata0_nxt;
    logic [DWIDTH-1:0] rdata1_nxt;
    logic              mem_we_nxt;
    logic              mem_re_nxt;
    logic [AWIDTH-1:0] mem_addr_nxt;
    logic [DWIDTH-1:0] mem_wdata_nxt;
    logic              busy_nxt;

    // Pick a winner: a lone requester wins outright, a tie goes to prio.
    always_comb begin
        win = 1'b0;
        if (req0 && req1) begin
            win = prio;
        end else if (req1) begin
            win = 1'b1;
        end
        win_we    = win ? we1    : we0;
        win_addr  = win ? addr1  : addr0;
        win_wdata = win ? wdata1 : wdata0;
    end

    // State register.
    always_ff @(posedge arb_clk) begin
        if (arb_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: writes finish from ISSUE, reads take an extra RESP cycle for the memory's registered read.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = mem_we ? IDLE : RESP;
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output logic: compute next values for every registered output.
    always_comb begin
        ack0_nxt      = 1'b0;
        ack1_nxt      = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_re_nxt    = 1'b0;
        rdata0_nxt    = rdata0;
        rdata1_nxt    = rdata1;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        prio_nxt      = prio;
        gnt_id_nxt    = gnt_id;
        busy_nxt      = (state_nxt != IDLE);
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_id_nxt    = win;
                    mem_addr_nxt  = win_addr;
                    mem_wdata_nxt = win_wdata;
                    mem_we_nxt    = win_we;
                    mem_re_nxt    = !win_we;
                end
            end
            ISSUE: begin
                // strobe is high this cycle; a write is complete once the memory samples it
                if (mem_we) begin
                    ack0_nxt = (gnt_id == 1'b0);
                    ack1_nxt = (gnt_id == 1'b1);
                    prio_nxt = ~gnt_id;
                end
            end
            RESP: begin
                // memory read data is valid now, one cycle after mem_re
                if (gnt_id == 1'b0) begin
                    rdata0_nxt = mem_rdata;
                    ack0_nxt   = 1'b1;
                end else begin
                    rdata1_nxt = mem_rdata;
                    ack1_nxt   = 1'b1;
                end
                prio_nxt = ~gnt_id;
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

    // Output and bookkeeping registers; reset aborts any access in flight without an ack.
    always_ff @(posedge arb_clk) begin
        if (arb_rst) begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            prio      <= 1'b0;
            gnt_id    <= 1'b0;
        end else begin
            ack0      <= ack0_nxt;
            ack1      <= ack1_nxt;
            rdata0    <= rdata0_nxt;
            rdata1    <= rdata1_nxt;
            mem_we    <= mem_we_nxt;
            mem_re    <= mem_re_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            busy      <= busy_nxt;
            prio      <= prio_nxt;
            gnt_id    <= gnt_id_nxt;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a registered data_mem model and two queue-driven requesters.
// Requesters drop or replace their command in the cycle they see ack, so a finished command is never re-granted.
// Each test task compares observed behaviour against hand-computed values.
module tb_dmem_arbiter;

    logic        arb_clk;
    logic        arb_rst;
    logic        req0, we0, ack0, req1, we1, ack1;
    logic [31:0] addr0, wdata0, rdata0, addr1, wdata1, rdata1;
    logic        mem_we, mem_re, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter #(.AWIDTH(32), .DWIDTH(32)) dut (
        .arb_clk(arb_clk), .arb_rst(arb_rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial arb_clk = 1'b0;
    always #5 arb_clk = ~arb_clk;

    int tot = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge arb_clk) cyc <= cyc + 1;

    // registered single-port memory model
    logic [31:0] mem [0:255];
    always @(posedge arb_clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    cmd_t        cq0[$];
    cmd_t        cq1[$];
    logic [31:0] rq0[$];
    logic [31:0] rq1[$];
    int          lat0[$];
    int          lat1[$];

    // monitor counters, written only by the monitor
    int n_we = 0, n_re = 0, n_ack0 = 0, n_ack1 = 0, n_busy = 0, viol = 0;
    logic [31:0] last_addr, last_wd;
    bit prev_strobe = 0;
    int acklog[$];

    always @(negedge arb_clk) begin
        if (ack0 === 1'b1 && ack1 === 1'b1) viol++;
        if (mem_we === 1'b1 && mem_re === 1'b1) viol++;
        if ((mem_we === 1'b1 || mem_re === 1'b1) && prev_strobe) viol++;
        prev_strobe = (mem_we === 1'b1 || mem_re === 1'b1);
        if (mem_we === 1'b1) begin n_we++; last_addr = mem_addr; last_wd = mem_wdata; end
        if (mem_re === 1'b1) begin n_re++; last_addr = mem_addr; end
        if (ack0 === 1'b1) begin n_ack0++; acklog.push_back(0); end
        if (ack1 === 1'b1) begin n_ack1++; acklog.push_back(1); end
        if (busy === 1'b1) n_busy++;
    end

    // port 0 requester
    initial begin
        int st;
        bit popped;
        st = 0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        forever begin
            @(posedge arb_clk); #1;
            popped = 0;
            if (ack0 === 1'b1 && cq0.size() > 0) begin
                rq0.push_back(rdata0); lat0.push_back(cyc - st); cq0.delete(0); popped = 1;
            end
            if (cq0.size() > 0) begin
                if (!req0 || popped) st = cyc;
                req0 = 1'b1; we0 = cq0[0].we; addr0 = cq0[0].addr; wdata0 = cq0[0].wdata;
            end else begin
                req0 = 1'b0;
            end
        end
    end

    // port 1 requester
    initial begin
        int st;
        bit popped;
        st = 0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        forever begin
            @(posedge arb_clk); #1;
            popped = 0;
            if (ack1 === 1'b1 && cq1.size() > 0) begin
                rq1.push_back(rdata1); lat1.push_back(cyc - st); cq1.delete(0); popped = 1;
            end
            if (cq1.size() > 0) begin
                if (!req1 || popped) st = cyc;
                req1 = 1'b1; we1 = cq1[0].we; addr1 = cq1[0].addr; wdata1 = cq1[0].wdata;
            end else begin
                req1 = 1'b0;
            end
        end
    end

    task automatic wait_done(input int p, input int target, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge arb_clk); #2;
            if ((p == 0 ? rq0.size() : rq1.size()) >= target) begin ok = 1; break; end
        end
        @(negedge arb_clk); #1;
    endtask

    task automatic push(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        cmd_t c;
        c.we = we; c.addr = a; c.wdata = d;
        if (p == 0) cq0.push_back(c); else cq1.push_back(c);
    endtask

    task automatic test_reset();
        arb_rst = 1'b1;
        repeat (3) @(posedge arb_clk);
        #1;
        tot++; if (ack0 !== 1'b0) begin bad++; $display("FAIL rst_ack0 got=%b exp=0", ack0); end
        tot++; if (ack1 !== 1'b0) begin bad++; $display("FAIL rst_ack1 got=%b exp=0", ack1); end
        tot++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
        tot++; if (mem_re !== 1'b0) begin bad++; $display("FAIL rst_mem_re got=%b exp=0", mem_re); end
        tot++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        tot++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
        tot++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
        tot++; if (rdata0 !== 32'h0) begin bad++; $display("FAIL rst_rdata0 got=%h exp=0", rdata0); end
        tot++; if (rdata1 !== 32'h0) begin bad++; $display("FAIL rst_rdata1 got=%h exp=0", rdata1); end
        arb_rst = 1'b0;
        repeat (2) @(posedge arb_clk);
    endtask

    task automatic test_write_p0();
        int b = rq0.size(); int sw = n_we; int sa1 = n_ack1; int sb = n_busy;
        bit ok;
        @(posedge arb_clk); #2;
        push(0, 1'b1, 32'd5, 32'hDEADBEEF);
        wait_done(0, b + 1, 20, ok);
        tot++; if (!ok) begin bad++; $display("FAIL wr_timeout got=none exp=ack0"); end
        else begin
            tot++; if (lat0[b] != 2) begin bad++; $display("FAIL wr_latency got=%0d exp=2", lat0[b]); end
        end
        tot++; if (n_we - sw != 1) begin bad++; $display("FAIL wr_we_cycles got=%0d exp=1", n_we - sw); end
        tot++; if (last_addr !== 32'd5) begin bad++; $display("FAIL wr_addr got=%h exp=5", last_addr); end
        tot++; if (last_wd !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_wdata got=%h exp=deadbeef", last_wd); end
        tot++; if (n_ack1 != sa1) begin bad++; $display("FAIL wr_ack1 got=%0d exp=0", n_ack1 - sa1); end
        tot++; if (n_busy - sb != 1) begin bad++; $display("FAIL wr_busy_cycles got=%0d exp=1", n_busy - sb); end
        tot++; if (mem[5] !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_mem5 got=%h exp=deadbeef", mem[5]); end
    endtask

    task automatic test_read_p0();
        int b = rq0.size(); int sr = n_re; int sw = n_we; int sb = n_busy;
        bit ok;
        @(posedge arb_clk); #2;
        push(0, 1'b0, 32'd5, 32'h0);
        wait_done(0, b + 1, 20, ok);
        tot++; if (!ok) begin bad++; $display("FAIL rd_timeout got=none exp=ack0"); end
        else begin
            tot++; if (lat0[b] != 3) begin bad++; $display("FAIL rd_latency got=%0d exp=3", lat0[b]); end
            tot++; if (rq0[b] !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", rq0[b]); end
        end
        tot++; if (rdata0 !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rdata0_hold got=%h exp=deadbeef", rdata0); end
        tot++; if (rdata1 !== 32'h0) begin bad++; $display("FAIL rd_rdata1 got=%h exp=0", rdata1); end
        tot++; if (n_re - sr != 1) begin bad++; $display("FAIL rd_re_cycles got=%0d exp=1", n_re - sr); end
        tot++; if (n_we != sw) begin bad++; $display("FAIL rd_no_we got=%0d exp=0", n_we - sw); end
        tot++; if (n_busy - sb != 2) begin bad++; $display("FAIL rd_busy_cycles got=%0d exp=2", n_busy - sb); end
    endtask

    task automatic test_both_writes();
        int lb; int b0; int b1;
        bit ok;
        @(posedge arb_clk); #1;
        arb_rst = 1'b1;
        repeat (2) @(posedge arb_clk);
        #1 arb_rst = 1'b0;
        @(posedge arb_clk); #2;
        lb = acklog.size(); b0 = rq0.size(); b1 = rq1.size();
        push(0, 1'b1, 32'd1, 32'd11);
        push(1, 1'b1, 32'd2, 32'd22);
        wait_done(1, b1 + 1, 30, ok);
        tot++; if (!ok || acklog.size() < lb + 2) begin bad++; $display("FAIL both_timeout got=%0d acks exp=2", acklog.size() - lb); end
        else begin
            tot++; if (acklog[lb] != 0) begin bad++; $display("FAIL both_first_grant got=%0d exp=0", acklog[lb]); end
            tot++; if (acklog[lb + 1] != 1) begin bad++; $display("FAIL both_second_grant got=%0d exp=1", acklog[lb + 1]); end
        end
        push(0, 1'b0, 32'd1, 32'h0);
        push(0, 1'b0, 32'd2, 32'h0);
        wait_done(0, b0 + 3, 40, ok);
        tot++; if (!ok) begin bad++; $display("FAIL both_readback_timeout got=%0d exp=%0d", rq0.size(), b0 + 3); end
        else begin
            tot++; if (rq0[b0 + 1] !== 32'd11) begin bad++; $display("FAIL both_mem1 got=%0d exp=11", rq0[b0 + 1]); end
            tot++; if (rq0[b0 + 2] !== 32'd22) begin bad++; $display("FAIL both_mem2 got=%0d exp=22", rq0[b0 + 2]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a0 [4];
        logic [31:0] e0 [4];
        logic [31:0] a1 [4];
        logic [31:0] e1 [4];
        int lb; int b0; int b1;
        bit ok0, ok1;
        a0 = '{32'd1, 32'd2, 32'd5, 32'd1};  e0 = '{32'd11, 32'd22, 32'hDEADBEEF, 32'd11};
        a1 = '{32'd5, 32'd1, 32'd2, 32'd5};  e1 = '{32'hDEADBEEF, 32'd11, 32'd22, 32'hDEADBEEF};
        @(posedge arb_clk); #2;
        lb = acklog.size(); b0 = rq0.size(); b1 = rq1.size();
        for (int i = 0; i < 4; i++) begin
            push(0, 1'b0, a0[i], 32'h0);
            push(1, 1'b0, a1[i], 32'h0);
        end
        wait_done(0, b0 + 4, 60, ok0);
        wait_done(1, b1 + 4, 60, ok1);
        tot++; if (!ok0 || !ok1 || acklog.size() != lb + 8) begin
            bad++; $display("FAIL b2b_count got=%0d acks exp=8", acklog.size() - lb);
        end else begin
            for (int i = 1; i < 8; i++) begin
                tot++; if (acklog[lb + i] == acklog[lb + i - 1]) begin
                    bad++; $display("FAIL b2b_alternate idx=%0d got=%0d exp=%0d", i, acklog[lb + i], 1 - acklog[lb + i - 1]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                tot++; if (rq0[b0 + i] !== e0[i]) begin bad++; $display("FAIL b2b_p0_data idx=%0d got=%h exp=%h", i, rq0[b0 + i], e0[i]); end
                tot++; if (rq1[b1 + i] !== e1[i]) begin bad++; $display("FAIL b2b_p1_data idx=%0d got=%h exp=%h", i, rq1[b1 + i], e1[i]); end
            end
        end
    endtask

    task automatic test_reset_resp();
        int b1; int sa1;
        bit found, ok;
        @(posedge arb_clk); #2;
        b1 = rq1.size(); sa1 = n_ack1;
        push(1, 1'b0, 32'd2, 32'h0);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge arb_clk);
            if (mem_re === 1'b1) begin found = 1; break; end
        end
        tot++; if (!found) begin bad++; $display("FAIL rr_no_issue got=0 exp=mem_re"); end
        @(posedge arb_clk); #2;
        arb_rst = 1'b1;
        @(posedge arb_clk); #1;
        tot++; if (ack1 !== 1'b0) begin bad++; $display("FAIL rr_ack1 got=%b exp=0", ack1); end
        tot++; if (rdata1 !== 32'h0) begin bad++; $display("FAIL rr_rdata1 got=%h exp=0", rdata1); end
        tot++; if ({ack0, mem_we, mem_re, busy} !== 4'b0) begin bad++; $display("FAIL rr_ctl got=%b exp=0000", {ack0, mem_we, mem_re, busy}); end
        tot++; if ({mem_addr, mem_wdata, rdata0} !== 96'h0) begin bad++; $display("FAIL rr_data got=%h exp=0", {mem_addr, mem_wdata, rdata0}); end
        #1 arb_rst = 1'b0;
        wait_done(1, b1 + 1, 20, ok);
        tot++; if (!ok) begin bad++; $display("FAIL rr_retry_timeout got=none exp=ack1"); end
        else begin
            tot++; if (rq1[b1] !== 32'd22) begin bad++; $display("FAIL rr_retry_data got=%h exp=16", rq1[b1]); end
        end
        tot++; if (n_ack1 - sa1 != 1) begin bad++; $display("FAIL rr_ack1_count got=%0d exp=1", n_ack1 - sa1); end
    endtask

    task automatic test_load_sweep();
        int s0 = n_ack0; int s1 = n_ack1; int b0 = rq0.size(); int b1 = rq1.size();
        bit ok;
        @(posedge arb_clk); #2;
        for (int i = 0; i < 10; i++) push(1, 1'b1, i, i);
        wait_done(1, b1 + 10, 100, ok);
        tot++; if (!ok) begin bad++; $display("FAIL sweep_load_timeout got=%0d exp=10", rq1.size() - b1); end
        for (int i = 0; i < 10; i++) push(0, 1'b0, i, 32'h0);
        wait_done(0, b0 + 10, 100, ok);
        tot++; if (!ok) begin bad++; $display("FAIL sweep_read_timeout got=%0d exp=10", rq0.size() - b0); end
        else begin
            for (int i = 0; i < 10; i++) begin
                tot++; if (rq0[b0 + i] !== i) begin bad++; $display("FAIL sweep_data addr=%0d got=%h exp=%h", i, rq0[b0 + i], i); end
            end
        end
        tot++; if (n_ack0 - s0 != 10) begin bad++; $display("FAIL sweep_ack0 got=%0d exp=10", n_ack0 - s0); end
        tot++; if (n_ack1 - s1 != 10) begin bad++; $display("FAIL sweep_ack1 got=%0d exp=10", n_ack1 - s1); end
        tot++; if (viol != 0) begin bad++; $display("FAIL invariants got=%0d exp=0", viol); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        arb_rst = 1'b1;
        test_reset();
        test_write_p0();
        test_read_p0();
        test_both_writes();
        test_back_to_back();
        test_reset_resp();
        test_load_sweep();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester, round-robin arbiter that shares one single-port data_mem instance between port 0 (CPU load/store unit) and port 1 (DMA/debug loader).
- Sits between the requesters and the data_mem we/re/addr/data_in/data_out pins.
- Serialises accesses one at a time and returns per-port acknowledge and read data.

Parameters:
- AWIDTH, 32, address width (matches data_mem).
- DWIDTH, 32, data width (matches data_mem).

Ports:
- arb_clk  in  1  sole clock.
- arb_rst  in  1  synchronous, active-high reset.
- req0  in  1  port 0 request; held high with cmd fields stable until ack0.
- we0  in  1  port 0: 1 = write, 0 = read.
- addr0  in  AWIDTH  port 0 address.
- wdata0  in  DWIDTH  port 0 write data.
- ack0  out  1  port 0 one-cycle completion pulse.
- rdata0  out  DWIDTH  port 0 read data, valid while ack0 = 1 for a read.
- req1, we1, addr1, wdata1, ack1, rdata1: same definitions for port 1.
- mem_we  out  1  to data_mem dm_we.
- mem_re  out  1  to data_mem dm_re.
- mem_addr  out  AWIDTH  to data_mem dm_addr.
- mem_wdata  out  DWIDTH  to data_mem dm_data_in.
- mem_rdata  in  DWIDTH  from data_mem dm_data_out; valid 1 cycle after mem_re.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset, sampled on the arb_clk edge while arb_rst = 1:
  - state = IDLE, prio = 0.
  - ack0, ack1, mem_we, mem_re, busy = 0.
  - mem_addr, mem_wdata, rdata0, rdata1 = 0.
- Reset asserted mid-transaction aborts it. No ack is issued and no further mem strobe occurs after the reset edge. A write strobe already issued is not undone.
- All outputs are registered.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If only one req is high, grant that port.
  - If both are high, grant the port equal to prio.
  - On grant: latch the winner's we, addr and wdata into mem_addr/mem_wdata; assert mem_we = we or mem_re = !we for exactly one cycle; set gnt_id; go to ISSUE.
- ISSUE (the mem strobe is high this cycle):
  - Write: on the next edge, pulse ack[gnt_id] for 1 cycle, drop the strobe, set prio = ~gnt_id, go to IDLE.
  - Read: on the next edge, drop mem_re and go to RESP.
- RESP:
  - Capture mem_rdata into rdata[gnt_id].
  - Pulse ack[gnt_id] for 1 cycle.
  - Set prio = ~gnt_id and go to IDLE.
- Latency from the req-sampled edge to ack high:
  - Write: 2 cycles.
  - Read: 3 cycles.
- Throughput: one access per 2 cycles (write) or 3 cycles (read). busy is high from the grant edge until the edge that returns to IDLE.
- Requester rules:
  - Deassert req, or present a new command, on the edge at which it samples ack = 1.
  - req high in IDLE always counts as a new request.
  - The losing port keeps req high; it is guaranteed the next grant.
- Command fields on a non-granted port are ignored. The arbiter does not re-read fields after grant.
- rdataN holds its last captured value between reads and is not modified by writes or by the other port.
- Only the granted port's ack pulses. ack0 and ack1 are never high in the same cycle.
- mem_we and mem_re are never high together and never high for more than one consecutive cycle.
- Addresses are passed through unmodified. Range and alignment are the memory's concern.

Test Plan:
- Reset, then port 0 writes addr 5 = 0xDEADBEEF: mem_we high exactly 1 cycle with mem_addr = 5; ack0 two edges after the req edge; ack1 stays 0.
- Port 0 reads addr 5 after that write: mem_re 1 cycle, then ack0 three edges after req with rdata0 = 0xDEADBEEF; rdata1 unchanged (0).
- Both ports write from reset (port 0: addr 1 = 11; port 1: addr 2 = 22), both holding req: port 0 granted first (prio = 0), port 1 next. Readback gives mem[1] = 11, mem[2] = 22. Grant order is 0,1.
- Both ports issue 4 back-to-back reads continuously: grants strictly alternate 0,1,0,1,... with no port granted twice in a row while the other waits.
- arb_rst asserted during RESP of a port 1 read: no ack1 pulse; all outputs 0 on the following cycle; a subsequent port 1 read completes normally with correct data.
- Port 1 loads addr 0..9 with value i, then port 0 reads addr 0..9: each rdata0 equals its address; 10 ack0 pulses, 10 ack1 pulses total.
